// File: rtl/conv_result_writer.sv
// Requantizes the accumulated-result stream, packs PACK_NUM elements per word,
// buffers words in a FIFO and drains them over a valid/ready write port.
// Optional padding checker (o_pad_err) enabled by CONV_WRITER_PAD_CHECK_EN.
module conv_result_writer #(
    parameter int RESULT_SIZE = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int PACK_NUM    = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [ADDR_W-1:0]               i_base_addr,
    input  logic [4:0]                      i_shift,
    input  logic [RESULT_SIZE-1:0]          i_result,
    input  logic [3:0]                      i_result_valid,
    input  logic                            i_conv_done,
    output logic                            o_wr_valid,
    input  logic                            i_wr_ready,
    output logic [ADDR_W-1:0]               o_wr_addr,
    output logic [PACK_NUM*OUT_WIDTH-1:0]   o_wr_data,
    output logic                            o_overflow,
    output logic [15:0]                     o_tile_cnt,
    output logic                            o_done
`ifdef CONV_WRITER_PAD_CHECK_EN
    ,
    output logic                            o_pad_err
`endif
);

    localparam int WORD_W = PACK_NUM * OUT_WIDTH;
    localparam int CNT_W  = $clog2(PACK_NUM);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic signed [RESULT_SIZE-1:0] Q_MAX =
        {{(RESULT_SIZE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RESULT_SIZE-1:0] Q_MIN =
        {{(RESULT_SIZE-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] Q_MAX_N = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] Q_MIN_N = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [4:0]               shift_reg;
    logic                     conv_done_d_reg;
    logic [OUT_WIDTH-1:0]     q_reg;
    logic                     q_valid_reg;
    logic [OUT_WIDTH-1:0]     pack_reg [PACK_NUM];
    logic [CNT_W-1:0]         pack_cnt_reg;
    logic                     push_req_reg;
    logic [WORD_W-1:0]        push_word_reg;
    logic [WORD_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]           fifo_cnt_reg;
    logic [ADDR_W-1:0]        wr_addr_reg;
    logic                     overflow_reg;
    logic [15:0]              tile_cnt_reg;

    logic                     accept;
    logic                     conv_edge;
    logic signed [RESULT_SIZE-1:0] shifted;
    logic [OUT_WIDTH-1:0]     q_sat;
    logic [OUT_WIDTH-1:0]     slot_in [PACK_NUM];
    logic [WORD_W-1:0]        word_in;
    logic                     pack_last, flush_emit, emit;
    logic                     fifo_empty, fifo_full, fifo_last;
    logic                     pop, pop_eff, fifo_wr, drop;

    assign accept    = (state_reg == ST_RUN) && !i_start && i_result_valid[0];
    assign conv_edge = i_conv_done && !conv_done_d_reg;

    // Arithmetic shift floors toward -inf; saturation is checked on the full width.
    assign shifted = $signed(i_result) >>> shift_reg;
    assign q_sat   = (shifted > Q_MAX) ? Q_MAX_N :
                     (shifted < Q_MIN) ? Q_MIN_N : shifted[OUT_WIDTH-1:0];

    // word_in is the pack register with the pending element already inserted.
    genvar gi;
    generate
        for (gi = 0; gi < PACK_NUM; gi++) begin : g_slot
            assign slot_in[gi] = (q_valid_reg && pack_cnt_reg == CNT_W'(gi)) ? q_reg : pack_reg[gi];
            assign word_in[gi*OUT_WIDTH +: OUT_WIDTH] = slot_in[gi];
        end
    endgenerate

    assign pack_last  = q_valid_reg && (pack_cnt_reg == CNT_W'(PACK_NUM-1));
    assign flush_emit = (state_reg == ST_FLUSH) && (q_valid_reg || pack_cnt_reg != '0);
    assign emit       = pack_last || flush_emit;

    assign fifo_empty = (fifo_cnt_reg == '0);
    assign fifo_full  = (fifo_cnt_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_last  = (fifo_cnt_reg == (PTR_W+1)'(1));
    assign pop        = !fifo_empty && i_wr_ready;
    assign pop_eff    = pop && !i_start;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign fifo_wr    = push_req_reg && !i_start && (!fifo_full || pop);
    assign drop       = push_req_reg && !i_start && fifo_full && !pop;

    assign o_wr_valid = !fifo_empty;
    assign o_wr_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign o_wr_addr  = wr_addr_reg;
    assign o_overflow = overflow_reg;
    assign o_tile_cnt = tile_cnt_reg;
    assign o_done     = (state_reg == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (i_start) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_IDLE:  ;
                ST_RUN:   if (conv_edge) state_next = ST_FLUSH;
                ST_FLUSH: state_next = ST_DRAIN;
                ST_DRAIN: begin
                    if (!push_req_reg && (fifo_empty || (fifo_last && pop))) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE:  ;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg       <= '0;
            conv_done_d_reg <= 1'b0;
            q_reg           <= '0;
            q_valid_reg     <= 1'b0;
            pack_cnt_reg    <= '0;
            push_req_reg    <= 1'b0;
            push_word_reg   <= '0;
            for (int i = 0; i < PACK_NUM; i++) begin
                pack_reg[i] <= '0;
            end
        end else begin
            conv_done_d_reg <= i_conv_done;
            q_valid_reg     <= accept;
            if (accept) begin
                q_reg <= q_sat;
            end
            if (i_start) begin
                shift_reg <= i_shift;
            end
            push_req_reg <= emit && !i_start;
            if (emit) begin
                push_word_reg <= word_in;
            end
            // Slots are zeroed on every emit so a flushed partial word is zero-filled.
            if (i_start || emit) begin
                pack_cnt_reg <= '0;
                for (int i = 0; i < PACK_NUM; i++) begin
                    pack_reg[i] <= '0;
                end
            end else if (q_valid_reg) begin
                pack_cnt_reg          <= pack_cnt_reg + CNT_W'(1);
                pack_reg[pack_cnt_reg] <= q_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg] <= push_word_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            wr_addr_reg  <= '0;
        end else if (i_start) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            wr_addr_reg  <= i_base_addr;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
                wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
            end
            case ({fifo_wr, pop_eff})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (PTR_W+1)'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (PTR_W+1)'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            tile_cnt_reg <= '0;
        end else if (i_start) begin
            overflow_reg <= 1'b0;
            tile_cnt_reg <= '0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (state_reg == ST_RUN && i_result_valid[2] && tile_cnt_reg != 16'hFFFF) begin
                tile_cnt_reg <= tile_cnt_reg + 16'd1;
            end
        end
    end

`ifdef CONV_WRITER_PAD_CHECK_EN
    logic pad_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_err_reg <= 1'b0;
        end else if (i_start) begin
            pad_err_reg <= 1'b0;
        end else if (state_reg == ST_RUN &&
                     ((i_result_valid[0] && !i_result_valid[1]) ||
                      (i_result_valid[3] && conv_done_d_reg))) begin
            pad_err_reg <= 1'b1;
        end
    end

    assign o_pad_err = pad_err_reg;
`else
    logic unused_valid_bits;
    assign unused_valid_bits = ^{i_result_valid[3], i_result_valid[1]};
`endif

endmodule
